env_gen: RTL and testbench
==========================

Name: env_gen

Overview:
- Time-multiplexed ADSR envelope generator for 3 voices. It is the responder to the master controller's envelope handshake.
- Each env_start_i pulse performs exactly one per-sample envelope update for the voice selected by voice_idx_i, using that voice's gate and ADSR nibbles.
- It returns the 8-bit envelope level with a one-cycle env_ready_o pulse, which the controller forwards to the multiplier.

Parameters:
- NUM_VOICES, 3, number of voice contexts held internally.
- CNT_W, 13, per-voice rate counter width; must hold 3x the largest period (4707).

Ports:
- clk_i, input, 1, system clock 50 MHz. Reset rst_ni is asynchronous, active-low; clock is clk_i.
- rst_ni, input, 1, asynchronous active-low reset.
- env_start_i, input, 1, one-cycle update request from controller.
- voice_idx_i, input, 2, voice to update (0..2 valid).
- env_gate_i, input, 1, gate bit of the selected voice.
- env_attack_i, input, 4, attack rate index.
- env_decay_i, input, 4, decay rate index.
- env_sustain_i, input, 4, sustain level nibble.
- env_release_i, input, 4, release rate index.
- env_ready_o, output, 1, one-cycle pulse: update complete, env_level_o valid.
- env_level_o, output, 8, envelope level of the last updated voice; holds value between updates.

Behaviour:
- Reset: env_ready_o=0, env_level_o=0. Every voice context: level=0, phase=RELEASE, prev_gate=0, counter=0.
- Per-voice context: level[7:0], phase{ATTACK, DECAY, RELEASE}, prev_gate, counter[CNT_W-1:0].
- Control FSM:
  - IDLE -> CALC when env_start_i=1. Latch voice_idx_i, gate and the ADSR nibbles on that edge.
  - CALC -> DONE. Compute and write back the context.
  - DONE -> IDLE. env_ready_o=1 and env_level_o updated in this cycle only.
- Latency: start sampled at edge k -> env_ready_o high for exactly the cycle after edge k+2. Minimum 3 cycles between accepted starts.
- env_start_i while not in IDLE is ignored. No queueing, no effect on the in-flight update.
- Period table P[r] (sample updates per level step), r=0..15: 1,2,3,5,7,11,13,16,20,49,98,157,196,588,980,1569.
  - Attack period = P[A].
  - Decay and release period = 3*P[D] and 3*P[R] (shift-add, no multiplier).
- Sustain level SL = {S,S}, i.e. S*17.
- Edge handling, checked first against prev_gate:
  - Rising (gate=1, prev=0): phase<=ATTACK, counter<=0, level unchanged (no reset to 0), no step this update.
  - Falling (gate=0, prev=1): phase<=RELEASE, counter<=0, no step.
  - prev_gate<=gate on every valid update.
- No edge:
  - If counter+1 >= period: counter<=0 and step phase. Otherwise counter<=counter+1.
  - Using >= means a rate change to a shorter period steps immediately.
- Step rules:
  - ATTACK: level+1. When the new level = 255, phase<=DECAY in the same update.
  - DECAY: if level > SL, level-1; else hold. No increment if SL rises above level.
  - RELEASE: if level > 0, level-1; else hold at 0.
- Decay and release are linear; no exponential curve.
- voice_idx_i=3: no context is modified, env_level_o<=0, env_ready_o still pulses with normal latency.
- Reset asserted mid-operation: FSM to IDLE, all contexts and outputs to reset values immediately; no ready pulse.
- Level arithmetic saturates: never wraps past 0 or 255.

Test Plan:
- Reset, then 1 start each for voices 0..2 with gate=0 -> three ready pulses, each 3 cycles after start, env_level_o=0 each time.
- Voice 1, A=0, gate=1 held, 256 starts -> levels 0,1,2,...,255. Phase DECAY after the 256th start. Voices 0/2 remain 0.
- Continue voice 1 with D=0, S=8 -> level decrements once every 3 updates. Reaches 0x88 after 357 further updates and holds at 0x88 for 50 more.
- Voice 1 gate=0, R=0 -> falling-edge update holds 0x88, then level decrements every 3 updates. Reaches 0 after 408 updates and stays 0.
- Retrigger: gate 1->0->1 at level 100 -> attack resumes from 100, not 0. A=1 gives +1 every 2 updates.
- Second env_start_i one cycle after the first -> only one ready pulse. voice_idx_i=3 -> ready pulse, level 0, no context changes. rst_ni low in CALC -> no ready, all levels 0.

Source files
------------

// File: rtl/env_gen.sv
// -----------------------------------------------------------------------------
// env_gen -- time-multiplexed ADSR envelope generator for NUM_VOICES voices.
//
// This block answers the master controller's envelope handshake. Each accepted
// env_start_i performs one per-sample envelope update for the selected voice.
// The block then returns that voice's 8-bit level with a one-cycle
// env_ready_o pulse.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   env_start_i    one-cycle update request (ignored unless idle)
//   voice_idx_i    voice to update; indices >= NUM_VOICES touch no context
//   env_gate_i     gate bit of the selected voice
//   env_attack_i   attack rate index  (period P[A])
//   env_decay_i    decay rate index   (period 3*P[D])
//   env_sustain_i  sustain nibble S   (sustain level {S,S})
//   env_release_i  release rate index (period 3*P[R])
//   env_ready_o    one-cycle pulse; env_level_o is valid with it
//   env_level_o    level of the last updated voice, held between updates
//
// Timing: start sampled at edge k -> context written at edge k+1 ->
// env_ready_o/env_level_o registered at edge k+2. A new start is accepted from
// edge k+3 onward.
// -----------------------------------------------------------------------------
module env_gen #(
  parameter int NUM_VOICES = 3,
  parameter int CNT_W      = 13
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       env_start_i,
  input  logic [1:0] voice_idx_i,
  input  logic       env_gate_i,
  input  logic [3:0] env_attack_i,
  input  logic [3:0] env_decay_i,
  input  logic [3:0] env_sustain_i,
  input  logic [3:0] env_release_i,
  output logic       env_ready_o,
  output logic [7:0] env_level_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] PH_ATTACK  = 2'd0;
  localparam logic [1:0] PH_DECAY   = 2'd1;
  localparam logic [1:0] PH_RELEASE = 2'd2;

  // Period table: number of sample updates per level step.
  function automatic logic [CNT_W-1:0] period_lut(input logic [3:0] r);
    logic [CNT_W-1:0] p;
    case (r)
      4'd0:    p = CNT_W'(1);
      4'd1:    p = CNT_W'(2);
      4'd2:    p = CNT_W'(3);
      4'd3:    p = CNT_W'(5);
      4'd4:    p = CNT_W'(7);
      4'd5:    p = CNT_W'(11);
      4'd6:    p = CNT_W'(13);
      4'd7:    p = CNT_W'(16);
      4'd8:    p = CNT_W'(20);
      4'd9:    p = CNT_W'(49);
      4'd10:   p = CNT_W'(98);
      4'd11:   p = CNT_W'(157);
      4'd12:   p = CNT_W'(196);
      4'd13:   p = CNT_W'(588);
      4'd14:   p = CNT_W'(980);
      default: p = CNT_W'(1569);
    endcase
    return p;
  endfunction

  // Decay/release run three times slower than attack; shift-add keeps the
  // multiplier out. 3*1569 = 4707 still fits in CNT_W bits.
  function automatic logic [CNT_W-1:0] triple(input logic [CNT_W-1:0] p);
    return (p << 1) + p;
  endfunction

  // Saturating increment: 255 stays 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] l);
    return (l == 8'hFF) ? l : l + 8'd1;
  endfunction

  // Decrement toward a floor without crossing it; holds when at or below it,
  // so a sustain level raised above the current level never pulls it upward.
  function automatic logic [7:0] sat_dec(input logic [7:0] l, input logic [7:0] floor_lvl);
    return (l > floor_lvl) ? l - 8'd1 : l;
  endfunction

  // Control state
  logic [1:0] state_q;

  // Per-voice contexts
  logic [7:0]       lvl_q   [NUM_VOICES];
  logic [1:0]       phase_q [NUM_VOICES];
  logic             pgate_q [NUM_VOICES];
  logic [CNT_W-1:0] cnt_q   [NUM_VOICES];

  // Stage p0: request fields captured at the accepting edge
  logic [1:0] vidx_p0;
  logic       gate_p0;
  logic [3:0] att_p0;
  logic [3:0] dec_p0;
  logic [3:0] sus_p0;
  logic [3:0] rel_p0;

  // Stage p1: result level waiting to be presented
  logic [7:0] lvl_p1;

  // Combinational update of the selected context
  logic             vld_voice;
  logic [1:0]       sel;
  logic [7:0]       cur_lvl;
  logic [1:0]       cur_ph;
  logic             cur_pgate;
  logic [CNT_W-1:0] cur_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] period;
  logic [7:0]       sus_lvl;
  logic [7:0]       nxt_lvl;
  logic [1:0]       nxt_ph;
  logic [CNT_W-1:0] nxt_cnt;

  logic accept;
  assign accept = (state_q == ST_IDLE) && env_start_i;

  // ---- stage p0: capture request ----
  always_ff @(posedge clk_i) begin
    if (accept) begin
      vidx_p0 <= voice_idx_i;
      gate_p0 <= env_gate_i;
      att_p0  <= env_attack_i;
      dec_p0  <= env_decay_i;
      sus_p0  <= env_sustain_i;
      rel_p0  <= env_release_i;
    end
  end

  // ---- stage p0 -> p1: envelope update ----
  always_comb begin
    vld_voice = (int'(vidx_p0) < NUM_VOICES);
    sel       = vld_voice ? vidx_p0 : 2'd0;
    cur_lvl   = lvl_q[sel];
    cur_ph    = phase_q[sel];
    cur_pgate = pgate_q[sel];
    cur_cnt   = cnt_q[sel];
    sus_lvl   = {sus_p0, sus_p0};
    cnt_inc   = cur_cnt + CNT_W'(1);

    case (cur_ph)
      PH_ATTACK: period = period_lut(att_p0);
      PH_DECAY:  period = triple(period_lut(dec_p0));
      default:   period = triple(period_lut(rel_p0));
    endcase

    nxt_lvl = cur_lvl;
    nxt_ph  = cur_ph;
    nxt_cnt = cur_cnt;

    if (gate_p0 && !cur_pgate) begin
      // Retrigger keeps the current level so attack resumes from it.
      nxt_ph  = PH_ATTACK;
      nxt_cnt = '0;
    end else if (!gate_p0 && cur_pgate) begin
      nxt_ph  = PH_RELEASE;
      nxt_cnt = '0;
    end else if (cnt_inc >= period) begin
      // >= so that switching to a shorter period steps right away.
      nxt_cnt = '0;
      case (cur_ph)
        PH_ATTACK: begin
          nxt_lvl = sat_inc(cur_lvl);
          if (nxt_lvl == 8'hFF) nxt_ph = PH_DECAY;
        end
        PH_DECAY: nxt_lvl = sat_dec(cur_lvl, sus_lvl);
        default:  nxt_lvl = sat_dec(cur_lvl, 8'd0);
      endcase
    end else begin
      nxt_cnt = cnt_inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == ST_CALC) lvl_p1 <= vld_voice ? nxt_lvl : 8'd0;
  end

  // ---- control FSM, context write-back and stage p1 -> output ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      env_ready_o <= 1'b0;
      env_level_o <= 8'd0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        lvl_q[i]   <= 8'd0;
        phase_q[i] <= PH_RELEASE;
        pgate_q[i] <= 1'b0;
        cnt_q[i]   <= '0;
      end
    end else begin
      env_ready_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (env_start_i) state_q <= ST_CALC;
        end
        ST_CALC: begin
          state_q <= ST_DONE;
          if (vld_voice) begin
            lvl_q[sel]   <= nxt_lvl;
            phase_q[sel] <= nxt_ph;
            pgate_q[sel] <= gate_p0;
            cnt_q[sel]   <= nxt_cnt;
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          env_ready_o <= 1'b1;
          env_level_o <= lvl_p1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_env_gen.sv
// -----------------------------------------------------------------------------
// tb_env_gen -- directed self-checking bench for env_gen.
// -----------------------------------------------------------------------------
module tb_env_gen;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       env_start_i = 1'b0;
  logic [1:0] voice_idx_i = 2'd0;
  logic       env_gate_i = 1'b0;
  logic [3:0] env_attack_i = 4'd0;
  logic [3:0] env_decay_i = 4'd0;
  logic [3:0] env_sustain_i = 4'd0;
  logic [3:0] env_release_i = 4'd0;
  logic       env_ready_o;
  logic [7:0] env_level_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] last_lvl;
  int         last_lat;
  logic       last_hold;

  env_gen #(.NUM_VOICES(3), .CNT_W(13)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .env_start_i   (env_start_i),
    .voice_idx_i   (voice_idx_i),
    .env_gate_i    (env_gate_i),
    .env_attack_i  (env_attack_i),
    .env_decay_i   (env_decay_i),
    .env_sustain_i (env_sustain_i),
    .env_release_i (env_release_i),
    .env_ready_o   (env_ready_o),
    .env_level_o   (env_level_o)
  );

  always #10 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One handshake. last_lat counts edges after the sampling edge until ready
  // is seen (2 expected); last_hold is ready one cycle after the pulse.
  task automatic upd(input logic [1:0] v, input logic g, input logic [3:0] a,
                     input logic [3:0] d, input logic [3:0] s, input logic [3:0] r);
    int cyc;
    @(posedge clk_i); #1;
    env_start_i = 1'b1; voice_idx_i = v; env_gate_i = g;
    env_attack_i = a; env_decay_i = d; env_sustain_i = s; env_release_i = r;
    @(posedge clk_i); #1;
    env_start_i = 1'b0;
    cyc = 0;
    while (!env_ready_o && cyc < 8) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    last_lat = cyc;
    last_lvl = env_level_o;
    @(posedge clk_i); #1;
    last_hold = env_ready_o;
  endtask

  initial begin
    int pulses;
    logic [7:0] pl;

    // Reset state
    #25;
    chk("rst_ready", env_ready_o, 0);
    chk("rst_level", env_level_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Each voice, gate low: ready two edges after sampling, level 0, one-cycle pulse
    for (int v = 0; v < 3; v++) begin
      upd(v[1:0], 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      chk("init_lat", last_lat, 2);
      chk("init_lvl", last_lvl, 0);
      chk("init_pulse_w", last_hold, 0);
    end

    // Attack A=0 on voice 1: 0,1,...,255
    for (int i = 0; i < 256; i++) begin
      upd(2'd1, 1'b1, 4'd0, 4'd0, 4'd8, 4'd0);
      chk("atk_lvl", last_lvl, i);
    end
    upd(2'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("v0_untouched", last_lvl, 0);
    upd(2'd2, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("v2_untouched", last_lvl, 0);

    // Decay D=0 (period 3), S=8 -> floor 0x88
    for (int j = 1; j <= 407; j++) begin
      upd(2'd1, 1'b1, 4'd0, 4'd0, 4'd8, 4'd0);
      chk("dec_lvl", last_lvl, (j <= 357) ? 255 - j / 3 : 136);
    end

    // Release R=0 (period 3)
    upd(2'd1, 1'b0, 4'd0, 4'd0, 4'd8, 4'd0);
    chk("rel_edge", last_lvl, 136);
    for (int j = 1; j <= 418; j++) begin
      upd(2'd1, 1'b0, 4'd0, 4'd0, 4'd8, 4'd0);
      chk("rel_lvl", last_lvl, (j <= 408) ? 136 - j / 3 : 0);
    end

    // Retrigger on voice 0 at level 100
    upd(2'd0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd15);
    chk("rt_rise0", last_lvl, 0);
    for (int i = 1; i <= 100; i++) upd(2'd0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd15);
    chk("rt_at100", last_lvl, 100);
    upd(2'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd15);
    chk("rt_fall", last_lvl, 100);
    upd(2'd0, 1'b1, 4'd1, 4'd0, 4'd0, 4'd15);
    chk("rt_rise", last_lvl, 100);
    for (int j = 1; j <= 6; j++) begin
      upd(2'd0, 1'b1, 4'd1, 4'd0, 4'd0, 4'd15);
      chk("rt_a1", last_lvl, 100 + j / 2);
    end

    // Rate change to shorter period steps immediately (voice 2)
    upd(2'd2, 1'b1, 4'd15, 4'd0, 4'd0, 4'd0);
    chk("rc_rise", last_lvl, 0);
    for (int i = 0; i < 5; i++) begin
      upd(2'd2, 1'b1, 4'd15, 4'd0, 4'd0, 4'd0);
      chk("rc_slow", last_lvl, 0);
    end
    upd(2'd2, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("rc_fast", last_lvl, 1);

    // Voice index 3: pulse with level 0, no context touched
    upd(2'd3, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("v3_lat", last_lat, 2);
    chk("v3_lvl", last_lvl, 0);
    upd(2'd2, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("v3_noctx", last_lvl, 2);

    // Second start one cycle after the first is ignored
    @(posedge clk_i); #1;
    env_start_i = 1'b1; voice_idx_i = 2'd2; env_gate_i = 1'b1;
    env_attack_i = 4'd0; env_decay_i = 4'd0; env_sustain_i = 4'd0; env_release_i = 4'd0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    env_start_i = 1'b0;
    pulses = 0;
    pl = 8'd0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_i); #1;
      if (env_ready_o) begin
        pulses++;
        pl = env_level_o;
      end
    end
    chk("dbl_pulses", pulses, 1);
    chk("dbl_lvl", pl, 3);
    upd(2'd2, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("dbl_after", last_lvl, 4);

    // Reset asserted while in CALC
    @(posedge clk_i); #1;
    env_start_i = 1'b1; voice_idx_i = 2'd0; env_gate_i = 1'b1;
    env_attack_i = 4'd0;
    @(posedge clk_i); #1;
    env_start_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_lvl", env_level_o, 0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk_i); #1;
      if (env_ready_o) pulses++;
      if (c == 2) rst_ni = 1'b1;
    end
    chk("mid_rst_pulses", pulses, 0);
    for (int v = 0; v < 3; v++) begin
      upd(v[1:0], 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      chk("post_rst_lvl", last_lvl, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
